exec_mem_unit: RTL and testbench

//  Decode, execute and data-memory stage of the single-cycle MIPS core.

---
 rtl/exec_mem_unit.sv | 207 ++++++++++++++++++++
 tb/tb_exec_mem_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_unit.sv
// Decode, ALU, branch compare and data memory for the single-cycle MIPS core.
// Ports: clk, reset (sync, low), instruction fields, rs/rt operands -> ALU, DM data, datapath selects.
module exec_mem_unit #(
  parameter int DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  rt_field,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm16,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_result,
  output logic [31:0] dm_rdata,
  output logic        grf_we,
  output logic [1:0]  waddr_sel,
  output logic [1:0]  wdata_sel,
  output logic [1:0]  npc_sel,
  output logic        dm_we,
  output logic        overflow
);

  localparam int IDX_W = $clog2(DM_WORDS);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

  typedef enum logic [1:0] {
    SA_SHAMT, SA_RS, SA_16
  } sa_sel_t;

  localparam logic [1:0] WA_RD  = 2'b00;
  localparam logic [1:0] WA_RT  = 2'b01;
  localparam logic [1:0] WA_31  = 2'b10;
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_PC4 = 2'b01;
  localparam logic [1:0] WD_DM  = 2'b10;
  localparam logic [1:0] NPC_4  = 2'b00;
  localparam logic [1:0] NPC_BR = 2'b01;
  localparam logic [1:0] NPC_J  = 2'b10;
  localparam logic [1:0] NPC_RS = 2'b11;

  alu_op_t     alu_op;
  sa_sel_t     sa_sel;
  logic        b_imm;
  logic        zext;
  logic        ovf_en;
  logic [31:0] ext_imm;
  logic [31:0] op_b;
  logic [4:0]  sa;
  logic [31:0] sum;
  logic [31:0] diff;
  logic        rs_neg;
  logic        rs_zero;

  assign rs_neg  = rs_data[31];
  assign rs_zero = (rs_data == 32'h0);

  always_comb begin
    alu_op    = ALU_ADD;
    sa_sel    = SA_SHAMT;
    b_imm     = 1'b0;
    zext      = 1'b0;
    ovf_en    = 1'b0;
    grf_we    = 1'b0;
    waddr_sel = WA_RD;
    wdata_sel = WD_ALU;
    npc_sel   = NPC_4;
    dm_we     = 1'b0;
    unique case (opcode)
      6'd0: begin
        grf_we = 1'b1;
        case (funct)
          6'd0:  alu_op = ALU_SLL;
          6'd2:  alu_op = ALU_SRL;
          6'd3:  alu_op = ALU_SRA;
          6'd4:  begin alu_op = ALU_SLL; sa_sel = SA_RS; end
          6'd6:  begin alu_op = ALU_SRL; sa_sel = SA_RS; end
          6'd7:  begin alu_op = ALU_SRA; sa_sel = SA_RS; end
          6'd8:  begin grf_we = 1'b0; npc_sel = NPC_RS; end
          6'd9:  begin npc_sel = NPC_RS; wdata_sel = WD_PC4; end
          6'd32: begin alu_op = ALU_ADD; ovf_en = 1'b1; end
          6'd33: alu_op = ALU_ADD;
          6'd34: begin alu_op = ALU_SUB; ovf_en = 1'b1; end
          6'd35: alu_op = ALU_SUB;
          6'd36: alu_op = ALU_AND;
          6'd37: alu_op = ALU_OR;
          6'd38: alu_op = ALU_XOR;
          6'd39: alu_op = ALU_NOR;
          6'd42: alu_op = ALU_SLT;
          6'd43: alu_op = ALU_SLTU;
          default: grf_we = 1'b0;
        endcase
      end
      6'd1: begin
        // REGIMM: rt field picks bltz/bgez, anything else is a nop
        if (rt_field == 5'd0 && rs_neg)  npc_sel = NPC_BR;
        if (rt_field == 5'd1 && !rs_neg) npc_sel = NPC_BR;
      end
      6'd2: npc_sel = NPC_J;
      6'd3: begin
        npc_sel   = NPC_J;
        grf_we    = 1'b1;
        waddr_sel = WA_31;
        wdata_sel = WD_PC4;
      end
      6'd4: if (rs_data == rt_data) npc_sel = NPC_BR;
      6'd5: if (rs_data != rt_data) npc_sel = NPC_BR;
      6'd6: if (rs_neg || rs_zero) npc_sel = NPC_BR;
      6'd7: if (!rs_neg && !rs_zero) npc_sel = NPC_BR;
      6'd8, 6'd9, 6'd10, 6'd11,
      6'd12, 6'd13, 6'd14, 6'd15: begin
        grf_we    = 1'b1;
        waddr_sel = WA_RT;
        b_imm     = 1'b1;
        case (opcode[2:0])
          3'd0: begin alu_op = ALU_ADD; ovf_en = 1'b1; end
          3'd1: alu_op = ALU_ADD;
          3'd2: alu_op = ALU_SLT;
          3'd3: alu_op = ALU_SLTU;
          3'd4: begin alu_op = ALU_AND; zext = 1'b1; end
          3'd5: begin alu_op = ALU_OR;  zext = 1'b1; end
          3'd6: begin alu_op = ALU_XOR; zext = 1'b1; end
          default: begin alu_op = ALU_SLL; sa_sel = SA_16; end
        endcase
      end
      6'd35: begin
        grf_we    = 1'b1;
        waddr_sel = WA_RT;
        wdata_sel = WD_DM;
        b_imm     = 1'b1;
      end
      6'd43: begin
        dm_we = 1'b1;
        b_imm = 1'b1;
      end
      default: ;
    endcase
  end

  assign ext_imm = zext ? {16'h0, imm16} : {{16{imm16[15]}}, imm16};
  assign op_b    = b_imm ? ext_imm : rt_data;
  assign sum     = rs_data + op_b;
  assign diff    = rs_data - op_b;

  always_comb begin
    sa = shamt;
    unique case (sa_sel)
      SA_RS:   sa = rs_data[4:0];
      SA_16:   sa = 5'd16;
      default: sa = shamt;
    endcase
  end

  always_comb begin
    alu_result = sum;
    overflow   = 1'b0;
    unique case (alu_op)
      ALU_ADD: begin
        alu_result = sum;
        overflow   = ovf_en & (rs_data[31] == op_b[31]) & (sum[31] != rs_data[31]);
      end
      ALU_SUB: begin
        alu_result = diff;
        overflow   = ovf_en & (rs_data[31] != op_b[31]) & (diff[31] != rs_data[31]);
      end
      ALU_AND:  alu_result = rs_data & op_b;
      ALU_OR:   alu_result = rs_data | op_b;
      ALU_XOR:  alu_result = rs_data ^ op_b;
      ALU_NOR:  alu_result = ~(rs_data | op_b);
      ALU_SLT:  alu_result = {31'h0, $signed(rs_data) < $signed(op_b)};
      ALU_SLTU: alu_result = {31'h0, rs_data < op_b};
      ALU_SLL:  alu_result = op_b << sa;
      ALU_SRL:  alu_result = op_b >> sa;
      ALU_SRA:  alu_result = $unsigned($signed(op_b) >>> sa);
      default:  alu_result = sum;
    endcase
  end

  logic [31:0]      mem_q [DM_WORDS];
  logic [IDX_W-1:0] dm_idx_d;
  logic [31:0]      dm_wdata_d;
  logic             dm_wen_d;

  // byte offset bits are dropped; upper address bits wrap the index
  always_comb begin
    dm_idx_d   = alu_result[IDX_W+1:2];
    dm_wdata_d = rt_data;
    dm_wen_d   = dm_we;
  end

  assign dm_rdata = mem_q[dm_idx_d];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= 32'h0;
    end else if (dm_wen_d) begin
      mem_q[dm_idx_d] <= dm_wdata_d;
    end
  end

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed bench for exec_mem_unit with an expected-value queue.
// Expectations are pushed per step and drained after outputs settle.
module tb_exec_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt_field;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] alu_result;
  logic [31:0] dm_rdata;
  logic        grf_we;
  logic [1:0]  waddr_sel;
  logic [1:0]  wdata_sel;
  logic [1:0]  npc_sel;
  logic        dm_we;
  logic        overflow;

  exec_mem_unit dut (
    .clk(clk), .reset(reset),
    .opcode(opcode), .funct(funct),
    .rt_field(rt_field), .shamt(shamt),
    .imm16(imm16), .rs_data(rs_data),
    .rt_data(rt_data), .alu_result(alu_result),
    .dm_rdata(dm_rdata), .grf_we(grf_we),
    .waddr_sel(waddr_sel), .wdata_sel(wdata_sel),
    .npc_sel(npc_sel), .dm_we(dm_we),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef enum int {S_ALU, S_RD, S_WE, S_WA, S_WD, S_NPC, S_DMW, S_OVF} sig_t;

  typedef struct {
    string       tag;
    sig_t        sig;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  task automatic push(input string tag, input sig_t s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rt, input logic [4:0] sh,
                       input logic [15:0] im, input logic [31:0] rs,
                       input logic [31:0] rtd);
    opcode   = op;
    funct    = fn;
    rt_field = rt;
    shamt    = sh;
    imm16    = im;
    rs_data  = rs;
    rt_data  = rtd;
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sig)
        S_ALU:   obs = alu_result;
        S_RD:    obs = dm_rdata;
        S_WE:    obs = {31'h0, grf_we};
        S_WA:    obs = {30'h0, waddr_sel};
        S_WD:    obs = {30'h0, wdata_sel};
        S_NPC:   obs = {30'h0, npc_sel};
        S_DMW:   obs = {31'h0, dm_we};
        default: obs = {31'h0, overflow};
      endcase
      total++;
      assert (obs === e.val) passed++;
      else $error("FAIL %s: got %h want %h", e.tag, obs, e.val);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive(6'd0, 6'd0, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    drive(6'd35, 6'd0, 5'd0, 5'd0, 16'h0000, 32'h0, 32'h0);
    push("lw0_rd", S_RD, 32'h0);
    push("lw0_alu", S_ALU, 32'h0);
    drain();
    drive(6'd35, 6'd0, 5'd0, 5'd0, 16'h0FFC, 32'h0, 32'h0);
    push("lwffc_rd", S_RD, 32'h0);
    push("lwffc_alu", S_ALU, 32'h0FFC);
    push("lw_wd", S_WD, 32'h2);
    push("lw_wa", S_WA, 32'h1);
    drain();

    drive(6'd13, 6'd0, 5'd0, 5'd0, 16'hFFFF, 32'h0, 32'h0);
    push("ori_alu", S_ALU, 32'h0000FFFF);
    push("ori_we", S_WE, 32'h1);
    push("ori_wa", S_WA, 32'h1);
    push("ori_wd", S_WD, 32'h0);
    drain();

    drive(6'd15, 6'd0, 5'd0, 5'd0, 16'h1234, 32'hFFFF_0000, 32'h0);
    push("lui_alu", S_ALU, 32'h12340000);
    drain();

    drive(6'd0, 6'd33, 5'd0, 5'd0, 16'h0, 32'h7FFFFFFF, 32'h1);
    push("addu_alu", S_ALU, 32'h80000000);
    drain();
    drive(6'd0, 6'd32, 5'd0, 5'd0, 16'h0, 32'h7FFFFFFF, 32'h1);
    push("add_alu", S_ALU, 32'h80000000);
    push("add_ovf", S_OVF, 32'h1);
    push("add_we", S_WE, 32'h1);
    drain();
    drive(6'd0, 6'd34, 5'd0, 5'd0, 16'h0, 32'h80000000, 32'h1);
    push("sub_alu", S_ALU, 32'h7FFFFFFF);
    push("sub_ovf", S_OVF, 32'h1);
    drain();
    drive(6'd8, 6'd0, 5'd0, 5'd0, 16'hFFFF, 32'h0, 32'h0);
    push("addi_alu", S_ALU, 32'hFFFFFFFF);
    push("addi_ovf", S_OVF, 32'h0);
    drain();
    drive(6'd12, 6'd0, 5'd0, 5'd0, 16'h8000, 32'hFFFFFFFF, 32'h0);
    push("andi_alu", S_ALU, 32'h00008000);
    drain();

    drive(6'd43, 6'd0, 5'd0, 5'd0, 16'hFFFC, 32'h10, 32'hDEADBEEF);
    push("sw_alu", S_ALU, 32'h0000000C);
    push("sw_dmw", S_DMW, 32'h1);
    push("sw_we", S_WE, 32'h0);
    push("sw_pre", S_RD, 32'h0);
    drain();
    @(negedge clk);
    drive(6'd35, 6'd0, 5'd0, 5'd0, 16'h0, 32'hC, 32'h0);
    push("lwc_rd", S_RD, 32'hDEADBEEF);
    push("lwc_we", S_WE, 32'h1);
    push("lwc_dmw", S_DMW, 32'h0);
    drain();
    drive(6'd35, 6'd0, 5'd0, 5'd0, 16'h0, 32'h100C, 32'h0);
    push("lw_wrap", S_RD, 32'hDEADBEEF);
    drain();
    drive(6'd35, 6'd0, 5'd0, 5'd0, 16'h0, 32'hF, 32'h0);
    push("lw_lowbits", S_RD, 32'hDEADBEEF);
    drain();
    drive(6'd35, 6'd0, 5'd0, 5'd0, 16'h0, 32'h8, 32'h0);
    push("lw_neigh", S_RD, 32'h0);
    drain();

    drive(6'd43, 6'd0, 5'd0, 5'd0, 16'h0, 32'h20, 32'h55);
    reset = 1'b0;
    push("rst_alu", S_ALU, 32'h20);
    push("rst_dmw", S_DMW, 32'h1);
    drain();
    @(negedge clk);
    reset = 1'b1;
    drive(6'd35, 6'd0, 5'd0, 5'd0, 16'h0, 32'h20, 32'h0);
    push("rst_sw", S_RD, 32'h0);
    drain();
    drive(6'd35, 6'd0, 5'd0, 5'd0, 16'h0, 32'hC, 32'h0);
    push("rst_clr", S_RD, 32'h0);
    drain();

    drive(6'd4, 6'd0, 5'd0, 5'd0, 16'h0, 32'h5, 32'h5);
    push("beq_t", S_NPC, 32'h1);
    push("beq_we", S_WE, 32'h0);
    drain();
    drive(6'd5, 6'd0, 5'd0, 5'd0, 16'h0, 32'h5, 32'h5);
    push("bne_nt", S_NPC, 32'h0);
    drain();
    drive(6'd5, 6'd0, 5'd0, 5'd0, 16'h0, 32'h5, 32'h6);
    push("bne_t", S_NPC, 32'h1);
    drain();
    drive(6'd1, 6'd0, 5'd1, 5'd0, 16'h0, 32'h80000000, 32'h0);
    push("bgez_nt", S_NPC, 32'h0);
    drain();
    drive(6'd1, 6'd0, 5'd0, 5'd0, 16'h0, 32'h80000000, 32'h0);
    push("bltz_t", S_NPC, 32'h1);
    drain();
    drive(6'd6, 6'd0, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0);
    push("blez_t", S_NPC, 32'h1);
    drain();
    drive(6'd7, 6'd0, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0);
    push("bgtz_nt", S_NPC, 32'h0);
    drain();

    drive(6'd3, 6'd0, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0);
    push("jal_npc", S_NPC, 32'h2);
    push("jal_wa", S_WA, 32'h2);
    push("jal_wd", S_WD, 32'h1);
    push("jal_we", S_WE, 32'h1);
    drain();
    drive(6'd2, 6'd0, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0);
    push("j_npc", S_NPC, 32'h2);
    push("j_we", S_WE, 32'h0);
    drain();
    drive(6'd0, 6'd8, 5'd0, 5'd0, 16'h0, 32'h400, 32'h0);
    push("jr_npc", S_NPC, 32'h3);
    push("jr_we", S_WE, 32'h0);
    drain();
    drive(6'd0, 6'd9, 5'd0, 5'd0, 16'h0, 32'h400, 32'h0);
    push("jalr_npc", S_NPC, 32'h3);
    push("jalr_we", S_WE, 32'h1);
    push("jalr_wd", S_WD, 32'h1);
    push("jalr_wa", S_WA, 32'h0);
    drain();

    drive(6'd0, 6'd42, 5'd0, 5'd0, 16'h0, 32'hFFFFFFFF, 32'h1);
    push("slt", S_ALU, 32'h1);
    drain();
    drive(6'd0, 6'd43, 5'd0, 5'd0, 16'h0, 32'hFFFFFFFF, 32'h1);
    push("sltu", S_ALU, 32'h0);
    drain();
    drive(6'd10, 6'd0, 5'd0, 5'd0, 16'h0001, 32'hFFFFFFFF, 32'h0);
    push("slti", S_ALU, 32'h1);
    drain();
    drive(6'd11, 6'd0, 5'd0, 5'd0, 16'hFFFF, 32'h1, 32'h0);
    push("sltiu", S_ALU, 32'h1);
    drain();

    drive(6'd0, 6'd3, 5'd0, 5'd4, 16'h0, 32'h0, 32'h80000000);
    push("sra", S_ALU, 32'hF8000000);
    drain();
    drive(6'd0, 6'd7, 5'd0, 5'd0, 16'h0, 32'd36, 32'h80000000);
    push("srav", S_ALU, 32'hF8000000);
    drain();
    drive(6'd0, 6'd2, 5'd0, 5'd4, 16'h0, 32'h0, 32'h80000000);
    push("srl", S_ALU, 32'h08000000);
    drain();
    drive(6'd0, 6'd39, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0);
    push("nor", S_ALU, 32'hFFFFFFFF);
    drain();

    drive(6'd63, 6'd0, 5'd0, 5'd0, 16'h0, 32'h5, 32'h5);
    push("unk_op_we", S_WE, 32'h0);
    push("unk_op_dmw", S_DMW, 32'h0);
    push("unk_op_npc", S_NPC, 32'h0);
    drain();
    drive(6'd0, 6'd1, 5'd0, 5'd0, 16'h0, 32'h5, 32'h5);
    push("unk_fn_we", S_WE, 32'h0);
    push("unk_fn_npc", S_NPC, 32'h0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
